timer_swreg: RTL and testbench
==============================

# timer_swreg

Software-visible control/status front end for the timer core. It sits directly upstream of the core:
- decodes native-bus (valid/ready) CPU accesses into the core's `TIMER_ENABLE` level and single-cycle `TIMER_SAMPLE` pulse;
- generates periodic auto-sample pulses;
- returns the core's sampled 64-bit `TIMER_VALUE` as two 32-bit words, with sticky sample/overrun status.

## Interface
Parameters:
- `DATA_W`, 32, bus data width; also the width of each half of `TIMER_VALUE`.
- `ADDR_W`, 3, word-address width.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `valid`  in  1  request strobe; each cycle high is one transaction.
- `address`  in  ADDR_W  word address.
- `wdata`  in  DATA_W  write data.
- `wstrb`  in  DATA_W/8  byte strobes; nonzero = write, zero = read.
- `rdata`  out  DATA_W  read data, valid while `ready`=1.
- `ready`  out  1  transaction-complete strobe.
- `TIMER_ENABLE`  out  1  count-enable level to core.
- `TIMER_SAMPLE`  out  1  one-cycle sample pulse to core.
- `TIMER_VALUE`  in  2*DATA_W  sampled counter from core.

## Operation
Register map (word address):
- **0 ENABLE**, RW: bit0 drives `TIMER_ENABLE`.
- **1 SAMPLE**, W:
  - a write with `wstrb[0]`=1 and `wdata[0]`=1 requests a sample;
  - reads return 0.
- **2 PERIOD**, RW, DATA_W bits:
  - byte-granular writes per `wstrb`;
  - 0 disables auto-sampling.
- **3 STATUS**:
  - bit0 SAMPLED (sticky), bit1 OVERRUN (sticky);
  - writing 1 to a bit clears it (W1C).
- **4 DATA_LOW**, R: `TIMER_VALUE[DATA_W-1:0]`.
- **5 DATA_HIGH**, R:
  - returns `TIMER_VALUE[2*DATA_W-1:DATA_W]`;
  - a read clears SAMPLED.
- **6, 7**: read 0; writes ignored.

ENABLE, SAMPLE and STATUS writes use only `wstrb[0]`.

Period generator:
- Counter `pcnt` counts 0..PERIOD-1 while ENABLE=1 and PERIOD≠0; otherwise it is held at 0.
- The cycle in which `pcnt`=PERIOD-1 raises an auto-sample request and `pcnt` wraps to 0. This gives one pulse every PERIOD cycles; PERIOD=1 gives a pulse every cycle.
- Any write to PERIOD clears `pcnt` to 0.

Sample merging and status:
- Manual and auto requests in the same cycle produce a single pulse.
- SAMPLED sets one cycle after the `TIMER_SAMPLE` pulse, which is when `TIMER_VALUE` has updated.
- OVERRUN sets if SAMPLED is already 1 at that point.
- A set and a clear (DATA_HIGH read or W1C) on the same edge: set wins.

## Timing
- Reset values: `rdata`=0, `ready`=0, `TIMER_ENABLE`=0, `TIMER_SAMPLE`=0, PERIOD=0, `pcnt`=0, SAMPLED=0, OVERRUN=0.
- Bus latency:
  - `ready` is registered and equals `valid` delayed by one cycle;
  - back-to-back transactions are supported, one per cycle;
  - `rdata` is registered from the register state at the accept cycle.
- Writes take effect at the clock edge ending the accept cycle t. `TIMER_ENABLE` changes in t+1.
- Manual sample:
  - `TIMER_SAMPLE` is high for exactly cycle t+1;
  - core value is valid at t+2;
  - SAMPLED reads as 1 for a read accepted at t+2 or later.
- Auto sample: the request cycle is where `pcnt`=PERIOD-1; `TIMER_SAMPLE` is high in the next cycle.
- Reset asserted mid-operation clears all state immediately, including any pulse in flight. No transaction completes across reset.

## Structure
- Shared package/header `timer_swreg_defs`:
  - register word addresses (ENABLE..DATA_HIGH);
  - STATUS bit indices;
  - `TIMER_ENABLE_W`, `TIMER_SAMPLE_W`, `TIMER_DATA_LOW_W`, `TIMER_DATA_HIGH_W`.
- The core uses the same width constants.
- One sub-module, `timer_period_gen`:
  - holds PERIOD compare, `pcnt` and the auto-request output;
  - inputs are enable, period, and clear-on-write.

## Test plan
- **Reset/idle:** after `rst` pulse, read all 8 addresses → 0, with `ready` exactly 1 cycle after each `valid`.
- **Manual sample:**
  - stimulus: write ENABLE=1, wait 100 cycles, write SAMPLE=1 at cycle t;
  - required: `TIMER_SAMPLE` high only at t+1;
  - required: STATUS=0x1; DATA_HIGH:DATA_LOW equals the core count at t+1;
  - required: after the DATA_HIGH read, STATUS=0.
- **Auto sample:**
  - stimulus: PERIOD=5, ENABLE=1;
  - required: `TIMER_SAMPLE` pulses exactly every 5 cycles;
  - required: rewriting PERIOD=5 mid-count restarts spacing from the write;
  - stimulus: then PERIOD=1;
  - required: continuous pulses.
- **Overrun/W1C:**
  - stimulus: PERIOD=3, no reads for 10 cycles;
  - required: STATUS=0x3;
  - stimulus: write STATUS=0x2;
  - required: STATUS=0x1, or 0x3 if a new pulse lands.
- **Collisions:**
  - manual SAMPLE write in the same cycle as auto request → single pulse;
  - DATA_HIGH read on the same edge as a SAMPLED set → SAMPLED stays 1.
- **Strobes/async reset:**
  - PERIOD write 0xAABBCCDD with `wstrb`=0b0100 over 0 → reads 0x00BB0000;
  - `rst` asserted mid-pulse → `TIMER_SAMPLE`=0 immediately and all registers 0.

Source files
------------

// File: rtl/timer_swreg_pkg.sv
// ---------------------------------------------------------------------------
// timer_swreg_pkg
// Shared definitions for the timer software-register front end and the timer
// core.
//   - Register word addresses (ENABLE .. DATA_HIGH).
//   - STATUS bit positions.
//   - Widths of the signals exchanged with the timer core.
// No ports (package).
// ---------------------------------------------------------------------------
package timer_swreg_pkg;

  // Widths of the core-facing signals. The core uses the same constants.
  localparam int TIMER_ENABLE_W    = 1;
  localparam int TIMER_SAMPLE_W    = 1;
  localparam int TIMER_DATA_LOW_W  = 32;
  localparam int TIMER_DATA_HIGH_W = 32;
  localparam int TIMER_VALUE_W     = TIMER_DATA_LOW_W + TIMER_DATA_HIGH_W;

  // Word addresses of the software-visible registers. Addresses 6 and 7 are
  // unused: they read as 0 and ignore writes.
  typedef enum logic [2:0] {
    ADDR_ENABLE    = 3'd0,
    ADDR_SAMPLE    = 3'd1,
    ADDR_PERIOD    = 3'd2,
    ADDR_STATUS    = 3'd3,
    ADDR_DATA_LOW  = 3'd4,
    ADDR_DATA_HIGH = 3'd5
  } reg_addr_e;

  // Bit positions inside STATUS.
  localparam int STATUS_SAMPLED_BIT = 0;
  localparam int STATUS_OVERRUN_BIT = 1;

endpackage

// File: rtl/timer_swreg_if.sv
// ---------------------------------------------------------------------------
// timer_swreg_if
// Native valid/ready CPU bus used to access timer_swreg.
//   valid   : request strobe; each cycle it is high is one transaction
//   address : word address
//   wdata   : write data
//   wstrb   : byte strobes; nonzero = write, zero = read
//   rdata   : read data, valid while ready = 1
//   ready   : completion strobe, one cycle after valid
// Modports: master (CPU side), slave (register block side).
// ---------------------------------------------------------------------------
interface timer_swreg_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
);

  logic                valid;
  logic [ADDR_W-1:0]   address;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic [DATA_W-1:0]   rdata;
  logic                ready;

  modport master (
    output valid, address, wdata, wstrb,
    input  rdata, ready
  );

  modport slave (
    input  valid, address, wdata, wstrb,
    output rdata, ready
  );

endinterface

// File: rtl/timer_period_gen.sv
// ---------------------------------------------------------------------------
// timer_period_gen
// Periodic auto-sample request generator.
// The counter runs 0..period-1 while enabled with a nonzero period. It raises
// auto_req in the cycle where it sits at period-1, then wraps to 0.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   enable   : counting allowed (ENABLE register)
//   period   : PERIOD register value; 0 disables auto-sampling
//   clear    : any PERIOD write; restarts the count from 0
//   auto_req : combinational auto-sample request
// ---------------------------------------------------------------------------
module timer_period_gen #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [DATA_W-1:0] period,
  input  logic              clear,
  output logic              auto_req
);

  logic [DATA_W-1:0] pcnt;
  logic              active;
  logic              at_end;

  // The request is taken from the current state. A PERIOD write in the same
  // cycle therefore does not suppress a request that is already due.
  always_comb begin
    active   = enable && (period != '0);
    at_end   = active && (pcnt == period - DATA_W'(1));
    auto_req = at_end;
  end

  // The counter is held at 0 whenever it is idle, so re-enabling always
  // starts a full period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt <= '0;
    end else if (clear || !active || at_end) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + DATA_W'(1);
    end
  end

endmodule

// File: rtl/timer_swreg.sv
// ---------------------------------------------------------------------------
// timer_swreg
// Software-visible control/status front end for the timer core.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   bus          : valid/ready CPU bus (slave modport)
//   TIMER_ENABLE : count-enable level to the core (ENABLE bit0)
//   TIMER_SAMPLE : one-cycle sample pulse to the core (manual or auto)
//   TIMER_VALUE  : sampled 64-bit counter from the core
// Register map: 0 ENABLE, 1 SAMPLE, 2 PERIOD, 3 STATUS (W1C),
//               4 DATA_LOW, 5 DATA_HIGH (read clears SAMPLED), 6/7 reserved.
// ---------------------------------------------------------------------------
module timer_swreg
  import timer_swreg_pkg::*;
#(
  parameter int DATA_W = TIMER_VALUE_W / 2,
  parameter int ADDR_W = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  timer_swreg_if.slave              bus,
  output logic [TIMER_ENABLE_W-1:0] TIMER_ENABLE,
  output logic [TIMER_SAMPLE_W-1:0] TIMER_SAMPLE,
  input  logic [2*DATA_W-1:0]       TIMER_VALUE
);

  logic              enable_reg;
  logic [DATA_W-1:0] period_reg;
  logic              sampled;
  logic              overrun;
  logic              sample_pulse;
  logic [DATA_W-1:0] rdata_reg;
  logic              ready_reg;

  logic              is_write;
  logic              is_read;
  logic              hit_enable;
  logic              hit_sample;
  logic              hit_period;
  logic              hit_status;
  logic              hit_low;
  logic              hit_high;
  logic              enable_wr;
  logic              period_wr;
  logic              manual_req;
  logic              auto_req;
  logic              clr_sampled;
  logic              clr_overrun;
  logic [DATA_W-1:0] period_merged;
  logic [DATA_W-1:0] rd_value;

  // Address decode and write/read qualification. ENABLE, SAMPLE and STATUS
  // only look at byte lane 0.
  always_comb begin
    is_write    = bus.valid && (bus.wstrb != '0);
    is_read     = bus.valid && (bus.wstrb == '0);
    hit_enable  = (bus.address == ADDR_W'(ADDR_ENABLE));
    hit_sample  = (bus.address == ADDR_W'(ADDR_SAMPLE));
    hit_period  = (bus.address == ADDR_W'(ADDR_PERIOD));
    hit_status  = (bus.address == ADDR_W'(ADDR_STATUS));
    hit_low     = (bus.address == ADDR_W'(ADDR_DATA_LOW));
    hit_high    = (bus.address == ADDR_W'(ADDR_DATA_HIGH));
    enable_wr   = is_write && hit_enable && bus.wstrb[0];
    period_wr   = is_write && hit_period;
    manual_req  = is_write && hit_sample && bus.wstrb[0] && bus.wdata[0];
    clr_sampled = (is_write && hit_status && bus.wstrb[0]
                   && bus.wdata[STATUS_SAMPLED_BIT])
                  || (is_read && hit_high);
    clr_overrun = is_write && hit_status && bus.wstrb[0]
                  && bus.wdata[STATUS_OVERRUN_BIT];
  end

  // Byte-lane merge for PERIOD writes.
  always_comb begin
    period_merged = period_reg;
    for (int b = 0; b < DATA_W / 8; b++) begin
      if (bus.wstrb[b]) begin
        period_merged[8*b +: 8] = bus.wdata[8*b +: 8];
      end
    end
  end

  // Read mux, evaluated on the register state of the accept cycle.
  always_comb begin
    rd_value = '0;
    if (hit_enable) begin
      rd_value[0] = enable_reg;
    end
    if (hit_period) begin
      rd_value = period_reg;
    end
    if (hit_status) begin
      rd_value[STATUS_SAMPLED_BIT] = sampled;
      rd_value[STATUS_OVERRUN_BIT] = overrun;
    end
    if (hit_low) begin
      rd_value = TIMER_VALUE[DATA_W-1:0];
    end
    if (hit_high) begin
      rd_value = TIMER_VALUE[2*DATA_W-1:DATA_W];
    end
  end

  timer_period_gen #(
    .DATA_W (DATA_W)
  ) u_period_gen (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable_reg),
    .period   (period_reg),
    .clear    (period_wr),
    .auto_req (auto_req)
  );

  // Register state, bus response and the sample pulse. SAMPLED/OVERRUN are
  // updated on the edge that ends the pulse cycle, when the core value has
  // just been captured; a set on that edge beats any clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable_reg   <= 1'b0;
      period_reg   <= '0;
      sampled      <= 1'b0;
      overrun      <= 1'b0;
      sample_pulse <= 1'b0;
      rdata_reg    <= '0;
      ready_reg    <= 1'b0;
    end else begin
      ready_reg    <= bus.valid;
      rdata_reg    <= is_read ? rd_value : '0;
      sample_pulse <= manual_req || auto_req;
      if (enable_wr) begin
        enable_reg <= bus.wdata[0];
      end
      if (period_wr) begin
        period_reg <= period_merged;
      end
      if (sample_pulse) begin
        sampled <= 1'b1;
      end else if (clr_sampled) begin
        sampled <= 1'b0;
      end
      if (sample_pulse && sampled) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

  assign bus.rdata    = rdata_reg;
  assign bus.ready    = ready_reg;
  assign TIMER_ENABLE = enable_reg;
  assign TIMER_SAMPLE = sample_pulse;

endmodule

// File: tb/tb_timer_swreg.sv
// ---------------------------------------------------------------------------
// tb_timer_swreg
// Testbench for timer_swreg. A small timer core stands in for the real one,
// and a cycle-level reference model of the register map predicts every bus
// response and sample pulse.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_timer_swreg;
  import timer_swreg_pkg::*;

  localparam int DW = 32;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [0:0]    timer_enable;
  logic [0:0]    timer_sample;
  logic [2*DW-1:0] timer_value;
  logic [2*DW-1:0] core_count;

  int checks = 0;
  int errors = 0;

  timer_swreg_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  timer_swreg #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .TIMER_ENABLE (timer_enable),
    .TIMER_SAMPLE (timer_sample),
    .TIMER_VALUE  (timer_value)
  );

  always #5 clk = ~clk;

  // Stand-in timer core: counts while enabled, captures on a sample pulse.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      core_count  <= '0;
      timer_value <= '0;
    end else begin
      if (timer_enable[0]) core_count <= core_count + 64'd1;
      if (timer_sample[0]) timer_value <= core_count;
    end
  end

  // Reference model state, describing the cycle currently in progress.
  bit          m_enable;
  logic [31:0] m_period;
  int unsigned m_phase;
  bit          m_sampled;
  bit          m_overrun;
  bit          m_pulse;
  bit          m_ready;
  logic [31:0] m_rdata;
  bit          m_was_read;
  logic [63:0] m_count;
  logic [63:0] m_value;

  function automatic bit model_auto_now();
    return m_enable && (m_period != 0) && (m_phase == m_period - 1);
  endfunction

  task automatic model_reset();
    m_enable = 0; m_period = 0; m_phase = 0; m_sampled = 0; m_overrun = 0;
    m_pulse = 0; m_ready = 0; m_rdata = 0; m_was_read = 0;
    m_count = 0; m_value = 0;
  endtask

  // Advances the model across one clock edge using the inputs currently on
  // the bus, then waits for that edge and settles 1 ns past it.
  task automatic tick();
    bit wr, rd, man, au, clr_s, clr_o, n_enable, n_sampled, n_overrun;
    logic [31:0] rv, np;
    logic [63:0] n_count, n_value;
    int unsigned n_phase;
    wr = bus.valid && (bus.wstrb != 4'h0);
    rd = bus.valid && (bus.wstrb == 4'h0);
    case (bus.address)
      3'd0: rv = {31'b0, m_enable};
      3'd2: rv = m_period;
      3'd3: rv = {30'b0, m_overrun, m_sampled};
      3'd4: rv = m_value[31:0];
      3'd5: rv = m_value[63:32];
      default: rv = 32'h0;
    endcase
    man   = wr && bus.address == 3'd1 && bus.wstrb[0] && bus.wdata[0];
    au    = model_auto_now();
    clr_s = (wr && bus.address == 3'd3 && bus.wstrb[0] && bus.wdata[0])
            || (rd && bus.address == 3'd5);
    clr_o = wr && bus.address == 3'd3 && bus.wstrb[0] && bus.wdata[1];
    n_sampled = m_pulse ? 1'b1 : (clr_s ? 1'b0 : m_sampled);
    n_overrun = (m_pulse && m_sampled) ? 1'b1 : (clr_o ? 1'b0 : m_overrun);
    n_count   = m_enable ? m_count + 64'd1 : m_count;
    n_value   = m_pulse ? m_count : m_value;
    n_enable  = (wr && bus.address == 3'd0 && bus.wstrb[0]) ? bus.wdata[0] : m_enable;
    np = m_period;
    if (wr && bus.address == 3'd2)
      for (int b = 0; b < 4; b++) if (bus.wstrb[b]) np[8*b +: 8] = bus.wdata[8*b +: 8];
    if (wr && bus.address == 3'd2) n_phase = 0;
    else if (m_enable && m_period != 0) n_phase = (m_phase + 1) % m_period;
    else n_phase = 0;
    m_ready    = bus.valid;
    m_rdata    = rd ? rv : 32'h0;
    m_was_read = rd;
    @(posedge clk);
    #1;
    m_enable = n_enable; m_period = np; m_phase = n_phase;
    m_sampled = n_sampled; m_overrun = n_overrun; m_pulse = man || au;
    m_count = n_count; m_value = n_value;
  endtask

  task automatic idle(input int n);
    bus.valid = 1'b0; bus.wstrb = 4'h0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s);
    bus.valid = 1'b1; bus.address = a; bus.wdata = d; bus.wstrb = s;
    tick();
    bus.valid = 1'b0; bus.wstrb = 4'h0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d, output logic r);
    bus.valid = 1'b1; bus.address = a; bus.wdata = $urandom; bus.wstrb = 4'h0;
    tick();
    d = bus.rdata; r = bus.ready;
    bus.valid = 1'b0;
  endtask

  task automatic do_reset();
    bus.valid = 1'b0; bus.wstrb = 4'h0;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic applyStimulus_dummy();
  endtask

  // Reset values, then all eight addresses read back as 0 with ready one
  // cycle after each request.
  task automatic test_reset();
    logic [31:0] d; logic r;
    do_reset();
    checks++;
    if (timer_enable !== 1'b0 || timer_sample !== 1'b0 || bus.ready !== 1'b0 || bus.rdata !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: en=%0b smp=%0b ready=%0b rdata=%h, required all 0",
               timer_enable, timer_sample, bus.ready, bus.rdata);
    end
    for (int a = 0; a < 8; a++) begin
      bus_read(3'(a), d, r);
      checks++;
      if (r !== 1'b1 || d !== 32'h0) begin
        errors++;
        $display("[TB] FAIL reset_read[%0d]: ready=%0b rdata=%h, required ready=1 rdata=0", a, r, d);
      end
    end
    idle(1);
    checks++;
    if (bus.ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ready_idle: ready=%0b, required 0", bus.ready);
    end
  endtask

  // Enable, 100 idle cycles, manual sample; the captured value is the core
  // count during the pulse cycle, which is 101 enabled cycles after the write.
  task automatic test_manual_sample();
    logic [31:0] d, lo; logic r;
    do_reset();
    bus_write(ADDR_ENABLE, 32'h1, 4'h1);
    checks++;
    if (timer_enable !== 1'b1) begin
      errors++; $display("[TB] FAIL enable_level: got %0b required 1", timer_enable);
    end
    for (int i = 0; i < 100; i++) begin
      idle(1);
      checks++;
      if (timer_sample !== 1'b0) begin
        errors++; $display("[TB] FAIL no_pulse_idle[%0d]: got %0b required 0", i, timer_sample);
      end
    end
    bus_write(ADDR_SAMPLE, 32'h1, 4'h1);
    checks++;
    if (timer_sample !== 1'b1) begin
      errors++; $display("[TB] FAIL manual_pulse_t1: got %0b required 1", timer_sample);
    end
    idle(1);
    checks++;
    if (timer_sample !== 1'b0) begin
      errors++; $display("[TB] FAIL manual_pulse_t2: got %0b required 0", timer_sample);
    end
    bus_read(ADDR_STATUS, d, r);
    checks++;
    if (d !== 32'h1) begin
      errors++; $display("[TB] FAIL manual_status: got %h required 00000001", d);
    end
    bus_read(ADDR_DATA_LOW, lo, r);
    bus_read(ADDR_DATA_HIGH, d, r);
    checks++;
    if ({d, lo} !== 64'd101 || {d, lo} !== m_value) begin
      errors++; $display("[TB] FAIL manual_value: got %0d required 101 (model %0d)", {d, lo}, m_value);
    end
    bus_read(ADDR_STATUS, d, r);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("[TB] FAIL status_after_high: got %h required 00000000", d);
    end
  endtask

  // PERIOD=5 spacing, restart on rewrite, then continuous pulses for PERIOD=1.
  task automatic test_auto_sample();
    bit exp;
    bus_write(ADDR_PERIOD, 32'd5, 4'hF);
    for (int c = 1; c <= 31; c++) begin
      if (c > 1) idle(1);
      exp = (c >= 6) && ((c - 1) % 5 == 0);
      checks++;
      if (timer_sample !== exp) begin
        errors++; $display("[TB] FAIL auto5[c=%0d]: got %0b required %0b", c, timer_sample, exp);
      end
    end
    idle($urandom_range(0, 4));
    bus_write(ADDR_PERIOD, 32'd5, 4'hF);
    checks++;
    if (timer_sample !== m_pulse) begin
      errors++; $display("[TB] FAIL rewrite_c1: got %0b required %0b", timer_sample, m_pulse);
    end
    for (int c = 2; c <= 12; c++) begin
      idle(1);
      exp = (c == 6) || (c == 11);
      checks++;
      if (timer_sample !== exp) begin
        errors++; $display("[TB] FAIL rewrite5[c=%0d]: got %0b required %0b", c, timer_sample, exp);
      end
    end
    bus_write(ADDR_PERIOD, 32'd1, 4'hF);
    for (int c = 2; c <= 12; c++) begin
      idle(1);
      checks++;
      if (timer_sample !== 1'b1) begin
        errors++; $display("[TB] FAIL period1[c=%0d]: got %0b required 1", c, timer_sample);
      end
    end
  endtask

  // Several samples with no DATA_HIGH read give OVERRUN; W1C clears it alone.
  task automatic test_overrun();
    logic [31:0] d; logic r;
    bus_write(ADDR_PERIOD, 32'd0, 4'hF);
    idle(3);
    bus_write(ADDR_STATUS, 32'h3, 4'h1);
    bus_read(ADDR_STATUS, d, r);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("[TB] FAIL status_cleared: got %h required 00000000", d);
    end
    bus_write(ADDR_PERIOD, 32'd3, 4'hF);
    idle(10);
    bus_read(ADDR_STATUS, d, r);
    checks++;
    if (d !== 32'h3 || d !== m_rdata) begin
      errors++; $display("[TB] FAIL overrun_status: got %h required 00000003", d);
    end
    bus_write(ADDR_STATUS, 32'h2, 4'h1);
    bus_read(ADDR_STATUS, d, r);
    checks++;
    if ((d !== 32'h1 && d !== 32'h3) || d !== m_rdata) begin
      errors++; $display("[TB] FAIL w1c_overrun: got %h required %h", d, m_rdata);
    end
  endtask

  // Manual write on the auto-request cycle merges into one pulse; a
  // DATA_HIGH read on the SAMPLED-set edge leaves SAMPLED at 1.
  task automatic test_collision();
    logic [31:0] d; logic r;
    int guard;
    bus_write(ADDR_PERIOD, 32'd4, 4'hF);
    guard = 0;
    while (!model_auto_now() && guard < 10) begin
      idle(1); guard++;
    end
    checks++;
    if (guard >= 10) begin
      errors++; $display("[TB] FAIL auto_wait: timeout after %0d cycles, required request within 10", guard);
    end
    bus_write(ADDR_SAMPLE, 32'h1, 4'h1);
    checks++;
    if (timer_sample !== 1'b1) begin
      errors++; $display("[TB] FAIL merged_pulse: got %0b required 1", timer_sample);
    end
    idle(1);
    checks++;
    if (timer_sample !== 1'b0) begin
      errors++; $display("[TB] FAIL merged_single: got %0b required 0", timer_sample);
    end
    bus_write(ADDR_PERIOD, 32'd0, 4'hF);
    idle(3);
    bus_write(ADDR_STATUS, 32'h3, 4'h1);
    bus_write(ADDR_SAMPLE, 32'h1, 4'h1);
    bus_read(ADDR_DATA_HIGH, d, r);
    bus_read(ADDR_STATUS, d, r);
    checks++;
    if (d !== 32'h1 || d !== m_rdata) begin
      errors++; $display("[TB] FAIL set_beats_clear: got %h required 00000001", d);
    end
  endtask

  // Byte-lane PERIOD writes, one directed and a few random.
  task automatic test_strobes();
    logic [31:0] d, wd; logic [3:0] ws; logic r;
    bus_write(ADDR_PERIOD, 32'h0, 4'hF);
    bus_write(ADDR_PERIOD, 32'hAABBCCDD, 4'b0100);
    bus_read(ADDR_PERIOD, d, r);
    checks++;
    if (d !== 32'h00BB0000) begin
      errors++; $display("[TB] FAIL strobe_lane2: got %h required 00BB0000", d);
    end
    for (int i = 0; i < 10; i++) begin
      wd = $urandom; ws = 4'($urandom_range(1, 15));
      bus_write(ADDR_PERIOD, wd, ws);
      bus_read(ADDR_PERIOD, d, r);
      checks++;
      if (d !== m_rdata) begin
        errors++; $display("[TB] FAIL strobe_rand[%0d]: wstrb=%h got %h required %h", i, ws, d, m_rdata);
      end
    end
  endtask

  // Random traffic on every address, compared each cycle with the model.
  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      bus.valid   = ($urandom_range(0, 9) < 6);
      bus.address = 3'($urandom_range(0, 7));
      bus.wstrb   = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'h0;
      bus.wdata   = (bus.address == 3'd2) ? 32'($urandom_range(0, 7)) : $urandom;
      tick();
      bus.valid = 1'b0;
      checks++;
      if (bus.ready !== m_ready || timer_sample !== m_pulse || timer_enable !== m_enable
          || (m_was_read && bus.rdata !== m_rdata)) begin
        errors++;
        $display("[TB] FAIL random[%0d]: ready=%0b smp=%0b en=%0b rdata=%h required ready=%0b smp=%0b en=%0b rdata=%h",
                 i, bus.ready, timer_sample, timer_enable, bus.rdata, m_ready, m_pulse, m_enable, m_rdata);
      end
    end
  endtask

  // Asynchronous reset in the middle of a pulse clears everything at once.
  task automatic test_async_reset();
    logic [31:0] d; logic r;
    bus_write(ADDR_ENABLE, 32'h1, 4'h1);
    bus_write(ADDR_PERIOD, 32'h1, 4'hF);
    idle(3);
    checks++;
    if (timer_sample !== 1'b1) begin
      errors++; $display("[TB] FAIL pre_reset_pulse: got %0b required 1", timer_sample);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (timer_sample !== 1'b0 || timer_enable !== 1'b0 || bus.ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset: smp=%0b en=%0b ready=%0b required all 0", timer_sample, timer_enable, bus.ready);
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();
    for (int a = 0; a < 8; a++) begin
      bus_read(3'(a), d, r);
      checks++;
      if (r !== 1'b1 || d !== 32'h0 || timer_sample !== 1'b0) begin
        errors++;
        $display("[TB] FAIL post_reset_read[%0d]: ready=%0b rdata=%h smp=%0b required 1/0/0", a, r, d, timer_sample);
      end
    end
  endtask

  initial begin
    bus.valid = 1'b0; bus.address = '0; bus.wdata = '0; bus.wstrb = '0;
    model_reset();
    test_reset();
    test_manual_sample();
    test_auto_sample();
    test_overrun();
    test_collision();
    test_strobes();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish within 2 ms");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
